// File: rtl/aes_uart_block_rx.sv
// aes_uart_block_rx
// UART receiver and block assembler feeding the AES core.
// Deserialises 8N1 frames (8E1 when UART_RX_PARITY_EN is defined), packs
// BLOCK_BYTES bytes into one wide word (first byte in the top byte) and
// presents it through a valid/ready holding register. The next block can
// assemble while the held block waits for the consumer.
//
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after data)
//
// Ports
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   uart_rx     asynchronous serial input, idle high
//   blk_ready   consumer accepts the held block
//   blk_valid   held block available
//   blk_data    held block, 8*BLOCK_BYTES bits
//   byte_cnt    bytes currently in the assembly register
//   rx_busy     receiver FSM not idle
//   frame_err   1-cycle pulse, stop bit sampled low
//   parity_err  1-cycle pulse, parity mismatch (0 without the macro)
//   overrun     1-cycle pulse, completed block dropped
module aes_uart_block_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int BLOCK_BYTES  = 16
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             uart_rx,
   input  logic                             blk_ready,
   output logic                             blk_valid,
   output logic [8*BLOCK_BYTES-1:0]         blk_data,
   output logic [$clog2(BLOCK_BYTES+1)-1:0] byte_cnt,
   output logic                             rx_busy,
   output logic                             frame_err,
   output logic                             parity_err,
   output logic                             overrun
);

   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int BCW  = $clog2(BLOCK_BYTES + 1);
   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int BW   = 8 * BLOCK_BYTES;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_BREAK
   } state_t;

   state_t         state, state_nx;
   logic [CW-1:0]  cnt, cnt_nx;
   logic [2:0]     bit_idx, bit_nx;
   logic [1:0]     sync_q;
   logic           rx_s;
   logic           bit_smp, stop_smp;
   logic [7:0]     shreg;
   logic [BW-1:0]  asm_reg, asm_next;
   logic           byte_ok;

   // two-flop synchroniser, reset to idle-high so reset never looks like a start bit
   always_ff @(posedge clk) begin
      if (!rst_n) sync_q <= 2'b11;
      else        sync_q <= {sync_q[0], uart_rx};
   end
   assign rx_s = sync_q[1];

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         bit_idx <= bit_nx;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_smp;
   logic par_bad;
`endif

   // next state and sample strobes
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + CW'(1);
      bit_nx   = bit_idx;
      bit_smp  = 1'b0;
      stop_smp = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_smp  = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            // cnt tracks cycles since the edge, so the edge cycle is 0
            cnt_nx = CW'(1);
            bit_nx = '0;
            if (!rx_s) state_nx = S_START;
         end
         S_START: begin
            if (cnt == CW'(HALF - 1)) begin
               cnt_nx = '0;
               if (rx_s) state_nx = S_IDLE;
               else      state_nx = S_DATA;
            end
         end
         S_DATA: begin
            if (cnt == CW'(CLKS_PER_BIT - 1)) begin
               cnt_nx  = '0;
               bit_smp = 1'b1;
               bit_nx  = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_nx = S_PARITY;
`else
                  state_nx = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (cnt == CW'(CLKS_PER_BIT - 1)) begin
               cnt_nx   = '0;
               par_smp  = 1'b1;
               state_nx = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (cnt == CW'(CLKS_PER_BIT - 1)) begin
               cnt_nx   = '0;
               stop_smp = 1'b1;
               // straight back to IDLE so a zero-gap start bit is caught
               if (rx_s) state_nx = S_IDLE;
               else      state_nx = S_BREAK;
            end
         end
         S_BREAK: begin
            // a line held low must go high before a new frame is accepted
            cnt_nx = '0;
            if (rx_s) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign rx_busy = (state != S_IDLE);

   always_comb begin
      asm_next      = asm_reg << 8;
      asm_next[7:0] = shreg;
   end

`ifdef UART_RX_PARITY_EN
   assign byte_ok = !par_bad;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         parity_err <= 1'b0;
         if (state == S_IDLE) par_bad <= 1'b0;
         if (par_smp) begin
            // even parity: data bits plus parity bit xor to 0
            par_bad    <= rx_s ^ (^shreg);
            parity_err <= rx_s ^ (^shreg);
         end
      end
   end
`else
   assign byte_ok    = 1'b1;
   assign parity_err = 1'b0;
`endif

   // data path: shift register, assembly, holding register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg     <= '0;
         asm_reg   <= '0;
         byte_cnt  <= '0;
         blk_data  <= '0;
         blk_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         if (blk_valid && blk_ready) blk_valid <= 1'b0;
         if (bit_smp) shreg <= {rx_s, shreg[7:1]};
         if (stop_smp) begin
            if (!rx_s) begin
               frame_err <= 1'b1;
            end else if (byte_ok) begin
               if (byte_cnt == BCW'(BLOCK_BYTES - 1)) begin
                  byte_cnt <= '0;
                  asm_reg  <= '0;
                  // a handshake this cycle frees the holding register
                  if (blk_valid && !blk_ready) begin
                     overrun <= 1'b1;
                  end else begin
                     blk_data  <= asm_next;
                     blk_valid <= 1'b1;
                  end
               end else begin
                  asm_reg  <= asm_next;
                  byte_cnt <= byte_cnt + BCW'(1);
               end
            end
         end
      end
   end

endmodule

// File: doc/aes_uart_block_rx.md
# aes_uart_block_rx

Parametrised UART receiver and block assembler feeding the AES core. It deserialises 8N1 bytes (optionally 8E1), packs `BLOCK_BYTES` consecutive bytes into one wide word, and hands it to the core through a valid/ready handshake. A double buffer lets the next block arrive while the current one waits for the core. Replaces the fixed-function receive path inside the UART/AES wrapper.

## Interface

- `CLKS_PER_BIT`, default 16, clock cycles per UART bit; ≥ 4.
- `BLOCK_BYTES`, default 16, bytes per assembled block; ≥ 1.
- `clk`  input  1  clock; all logic on rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `uart_rx`  input  1  asynchronous serial line, idle high.
- `blk_ready`  input  1  consumer accepts the held block.
- `blk_valid`  output  1  held block available.
- `blk_data`  output  8*BLOCK_BYTES  held block; first received byte in the top byte.
- `byte_cnt`  output  clog2(BLOCK_BYTES+1)  bytes in the assembly buffer.
- `rx_busy`  output  1  FSM not in IDLE.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled 0.
- `parity_err`  output  1  one-cycle pulse: parity mismatch (tied 0 without the macro).
- `overrun`  output  1  one-cycle pulse: completed block dropped.

## Operation

- `uart_rx` passes through a 2-flop synchroniser. Both flops reset to 1.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- IDLE: when the synchronised line is 0, clear the bit counter and go to START.
- START: sample at count CLKS_PER_BIT/2−1.
  - If the line is 1, this is a false start; return to IDLE.
  - Otherwise restart the counter and go to DATA.
- DATA: sample every CLKS_PER_BIT cycles. Data is LSB first; 8 samples, then go to PARITY or STOP.
- STOP: sample once.
  - 1: the byte is accepted if no parity error occurred. Go to IDLE.
  - 0: pulse `frame_err`, discard the byte, go to BREAK.
- BREAK: wait until the line is 1, then go to IDLE. This prevents a held-low line from retriggering.
- Accepted byte: shift the assembly register left by 8, load the byte into bits [7:0], and increment `byte_cnt`.
- When the count reaches BLOCK_BYTES:
  - The assembly register moves to the holding register and `byte_cnt` returns to 0.
  - The first received byte ends up in `blk_data[8*BLOCK_BYTES-1 -: 8]`.
- Holding register: `blk_valid` is set on load and cleared on the cycle after `blk_valid && blk_ready`. `blk_data` stays stable while `blk_valid` is 1.
- Block completes while `blk_valid=1` and no handshake happens that cycle: the new block is discarded, `overrun` pulses, and the held block is unchanged.
- Block completes on the same cycle as a handshake: the new block loads and `blk_valid` stays 1.
- Reset values:
  - `blk_valid=0`, `blk_data=0`, `byte_cnt=0`, `rx_busy=0`.
  - All pulses 0; FSM in IDLE.
  - Reset mid-byte or mid-block discards all partial data.

## Timing

- Line-to-FSM latency is 2 cycles (synchroniser).
- Sample points, with the falling edge of the start bit at cycle 0 after synchronisation:
  - Start bit: cycle CLKS_PER_BIT/2−1.
  - Data bit k (k=0..7): cycle CLKS_PER_BIT/2−1 + (k+1)·CLKS_PER_BIT.
  - Stop bit: the next CLKS_PER_BIT step after the last data or parity sample.
- `byte_cnt` updates 1 cycle after the stop sample.
- `blk_valid` rises 1 cycle after the stop sample of the last byte.
- All error pulses are registered and appear 1 cycle after the offending sample.
- Back-to-back bytes with zero idle time are received without loss. The FSM re-enters IDLE immediately after the stop sample.
- `blk_ready` is a don't-care while `blk_valid=0`.

## Configuration

- `UART_RX_PARITY_EN` defined:
  - After DATA, the PARITY state samples one even-parity bit.
  - On mismatch, `parity_err` pulses; the stop bit is still checked, and the byte is discarded whatever the stop result.
- `UART_RX_PARITY_EN` undefined:
  - The PARITY state and its logic are absent; the frame is 8N1.
  - `parity_err` is constant 0.

## Test plan

- Reset with `uart_rx=1`: all outputs 0 and FSM idle. Then send bytes 0x00..0x0F (BLOCK_BYTES=16, CLKS_PER_BIT=16, `blk_ready=1`) → `blk_valid` pulses 1 cycle with `blk_data`=0x000102030405060708090A0B0C0D0E0F.
- 1-cycle low glitch on `uart_rx` → no byte, `rx_busy` returns 0, `byte_cnt=0`.
- Send 0x55 with stop bit 0, hold the line low for 40 cycles, then send 0xA3 → `frame_err` pulses once, no retrigger during the low period, `byte_cnt=1`, and the assembly register's low byte is 0xA3.
- `blk_ready=0`, send two full blocks (A then B) → first block held stable, `overrun` pulses once at B's completion. Raise `blk_ready` → A is delivered and `blk_valid` falls.
- Assert `rst_n=0` for 1 cycle after 5 bytes of a block → `byte_cnt=0`. The next 16 bytes form a clean block.
- With `UART_RX_PARITY_EN`: send 0x07 with parity bit 0 → `parity_err` pulses and `byte_cnt` is unchanged. Resend with parity bit 1 → `byte_cnt` increments.
